point_scalar_mult: RTL and testbench

- Computes R = k·P over the curve in elliptic_curve_structs using left-to-right double-and-add on affine points.
- Acts as the initiator/sequencer for the existing point_double and point_add responders. It drives their Reset-gated start protocol, waits on their Done, and latches their results.
- Sits between the MSM bucket/window logic and the point primitives. It is the single-point scalar-multiply engine.

---
 rtl/elliptic_curve_structs.sv | 39 +++
 rtl/point_scalar_mult_pkg.sv | 8 +
 rtl/point_scalar_mult_if.sv | 17 +
 rtl/point_add.sv | 39 +++
 rtl/point_double.sv | 41 ++++
 rtl/point_scalar_mult.sv | 177 +++++++++++++++++
 tb/tb_point_scalar_mult.sv | 242 ++++++++++++++++++++++++
 7 files changed

// File: rtl/elliptic_curve_structs.sv
// Shared curve definitions: y^2 = x^3 + 2x + 2 over GF(17), generator G=(5,1) of prime order 19.
package elliptic_curve_structs;

    localparam int unsigned P_WIDTH = 5;
    localparam int unsigned P_MOD   = 17;
    localparam int unsigned CURVE_A = 2;
    localparam int unsigned N_ORDER = 19;
    localparam int unsigned G_X     = 5;
    localparam int unsigned G_Y     = 1;
    localparam int unsigned SW      = P_WIDTH + 1;
    localparam int unsigned DW      = 2 * P_WIDTH;

    typedef logic [P_WIDTH-1:0] felem_t;

    typedef struct packed {
        felem_t x;
        felem_t y;
    } curve_point_t;

    function automatic felem_t f_add(felem_t a, felem_t b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s >= SW'(P_MOD)) s = s - SW'(P_MOD);
        return P_WIDTH'(s);
    endfunction

    // Wraps modulo 2^P_WIDTH in the borrow case; the true result is below P_MOD.
    function automatic felem_t f_sub(felem_t a, felem_t b);
        if (a >= b) return a - b;
        return a + P_WIDTH'(P_MOD) - b;
    endfunction

    function automatic felem_t f_mul(felem_t a, felem_t b);
        logic [DW-1:0] t;
        t = DW'(a) * DW'(b);
        return P_WIDTH'(t % DW'(P_MOD));
    endfunction

endpackage

// File: rtl/point_scalar_mult_pkg.sv
// Local helpers for the scalar-multiply engine.
package point_scalar_mult_pkg;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/point_scalar_mult_if.sv
// Request/result bus of the scalar-multiply engine.
interface point_scalar_mult_if
    import elliptic_curve_structs::*;
#(
    parameter int unsigned K_WIDTH = P_WIDTH
);
    logic               start;
    logic [K_WIDTH-1:0] k;
    curve_point_t       P;
    logic               busy;
    logic               Done;
    curve_point_t       R;
    logic               R_inf;

    modport master (output start, k, P, input busy, Done, R, R_inf);
    modport slave  (input start, k, P, output busy, Done, R, R_inf);
endinterface

// File: rtl/point_add.sv
// Affine point addition responder (P != +-Q): runs while Reset is low, raises Done and holds R.
module point_add
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);
    felem_t       inv;
    felem_t       lam_c;
    felem_t       x3_c;
    logic         hit_c;
    curve_point_t r_c;

    always_comb begin
        hit_c = (f_mul(f_sub(Q.x, P.x), inv) == P_WIDTH'(1));
        lam_c = f_mul(f_sub(Q.y, P.y), inv);
        x3_c  = f_sub(f_sub(f_mul(lam_c, lam_c), P.x), Q.x);
        r_c   = '{x: x3_c, y: f_sub(f_mul(lam_c, f_sub(P.x, x3_c)), P.y)};
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            inv  <= P_WIDTH'(1);
            R    <= '0;
            Done <= 1'b0;
        end else if (!Done) begin
            if (hit_c) begin
                R    <= r_c;
                Done <= 1'b1;
            end else begin
                inv <= inv + P_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/point_double.sv
// Affine point doubling responder: runs while Reset is low, raises Done and holds R.
module point_double
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    output curve_point_t R,
    output logic         Done
);
    felem_t       inv;
    felem_t       x2_c;
    felem_t       lam_c;
    felem_t       x3_c;
    logic         hit_c;
    curve_point_t r_c;

    // Inverse of 2y found by stepping candidates until den*inv == 1.
    always_comb begin
        x2_c  = f_mul(P.x, P.x);
        hit_c = (f_mul(f_add(P.y, P.y), inv) == P_WIDTH'(1));
        lam_c = f_mul(f_add(f_add(f_add(x2_c, x2_c), x2_c), P_WIDTH'(CURVE_A)), inv);
        x3_c  = f_sub(f_mul(lam_c, lam_c), f_add(P.x, P.x));
        r_c   = '{x: x3_c, y: f_sub(f_mul(lam_c, f_sub(P.x, x3_c)), P.y)};
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            inv  <= P_WIDTH'(1);
            R    <= '0;
            Done <= 1'b0;
        end else if (!Done) begin
            if (hit_c) begin
                R    <= r_c;
                Done <= 1'b1;
            end else begin
                inv <= inv + P_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/point_scalar_mult.sv
// R = k*P by left-to-right double-and-add, sequencing one point_double and one point_add.
module point_scalar_mult
    import elliptic_curve_structs::*;
    import point_scalar_mult_pkg::*;
#(
    parameter int unsigned K_WIDTH = P_WIDTH
)
(
    input  logic              clk,
    input  logic              Reset,
    point_scalar_mult_if.slave bus
);
    localparam int unsigned IW = idx_width(K_WIDTH);

    typedef enum logic [2:0] {IDLE, SCAN, DBL_RUN, ADD_CHK, ADD_RUN, FIN} state_t;

    state_t             state, state_nx;
    logic [K_WIDTH-1:0] kr, kr_nx;
    curve_point_t       pr, pr_nx, q, q_nx, r_q, r_nx;
    logic [IW-1:0]      idx, idx_nx;
    logic               qinf, qinf_nx, add_pend, add_pend_nx;
    logic               dbl_rst, dbl_rst_nx, add_rst, add_rst_nx;
    logic               busy_q, busy_nx, done_q, done_nx, r_inf_q, r_inf_nx;
    logic               adv;
    logic               dbl_reset_c, add_reset_c, dbl_done, add_done;
    curve_point_t       dbl_r, add_r;

    assign dbl_reset_c = Reset | dbl_rst;
    assign add_reset_c = Reset | add_rst;
    assign bus.busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.R       = r_q;
    assign bus.R_inf   = r_inf_q;

    point_double dbl0 (.clk(clk), .Reset(dbl_reset_c), .P(q), .R(dbl_r), .Done(dbl_done));
    point_add    add0 (.clk(clk), .Reset(add_reset_c), .P(q), .Q(pr), .R(add_r), .Done(add_done));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            kr       <= '0;
            pr       <= '0;
            q        <= '0;
            idx      <= '0;
            qinf     <= 1'b1;
            add_pend <= 1'b0;
            dbl_rst  <= 1'b1;
            add_rst  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r_q      <= '0;
            r_inf_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            kr       <= kr_nx;
            pr       <= pr_nx;
            q        <= q_nx;
            idx      <= idx_nx;
            qinf     <= qinf_nx;
            add_pend <= add_pend_nx;
            dbl_rst  <= dbl_rst_nx;
            add_rst  <= add_rst_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            r_q      <= r_nx;
            r_inf_q  <= r_inf_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        kr_nx       = kr;
        pr_nx       = pr;
        q_nx        = q;
        idx_nx      = idx;
        qinf_nx     = qinf;
        add_pend_nx = add_pend;
        dbl_rst_nx  = dbl_rst;
        add_rst_nx  = add_rst;
        busy_nx     = busy_q;
        done_nx     = done_q;
        r_nx        = r_q;
        r_inf_nx    = r_inf_q;
        adv         = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    kr_nx    = bus.k;
                    pr_nx    = bus.P;
                    idx_nx   = IW'(K_WIDTH - 1);
                    qinf_nx  = 1'b1;
                    done_nx  = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (kr[idx]) begin
                    q_nx    = pr;
                    qinf_nx = 1'b0;
                end
                if (idx == '0) begin
                    state_nx = FIN;
                end else begin
                    idx_nx = idx - IW'(1);
                    if (kr[idx]) begin
                        add_pend_nx = 1'b1;
                        state_nx    = DBL_RUN;
                    end
                end
            end
            // Entry cycle (dbl_rst still high) screens out results that are infinity.
            DBL_RUN: begin
                if (dbl_rst) begin
                    if (qinf || q.y == '0) begin
                        qinf_nx = 1'b1;
                        if (add_pend) state_nx = ADD_CHK;
                        else          adv      = 1'b1;
                    end else begin
                        dbl_rst_nx = 1'b0;
                    end
                end else if (dbl_done) begin
                    q_nx       = dbl_r;
                    dbl_rst_nx = 1'b1;
                    if (add_pend) state_nx = ADD_CHK;
                    else          adv      = 1'b1;
                end
            end
            ADD_CHK: begin
                if (!kr[idx]) begin
                    adv = 1'b1;
                end else if (qinf) begin
                    q_nx    = pr;
                    qinf_nx = 1'b0;
                    adv     = 1'b1;
                end else if (q.x != pr.x) begin
                    add_rst_nx = 1'b0;
                    state_nx   = ADD_RUN;
                end else if (q.y == pr.y) begin
                    // Q == P: the sum is a doubling of P, and the bit is then consumed.
                    q_nx        = pr;
                    add_pend_nx = 1'b0;
                    state_nx    = DBL_RUN;
                end else begin
                    qinf_nx = 1'b1;
                    adv     = 1'b1;
                end
            end
            ADD_RUN: begin
                if (add_done) begin
                    q_nx       = add_r;
                    add_rst_nx = 1'b1;
                    adv        = 1'b1;
                end
            end
            FIN: begin
                r_nx     = qinf ? '0 : q;
                r_inf_nx = qinf;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (adv) begin
            if (idx == '0) begin
                state_nx = FIN;
            end else begin
                idx_nx      = idx - IW'(1);
                add_pend_nx = 1'b1;
                state_nx    = DBL_RUN;
            end
        end
    end
endmodule

// File: tb/tb_point_scalar_mult.sv
// Directed and randomized checks of point_scalar_mult against an integer group-law model.
module tb_point_scalar_mult;
    import elliptic_curve_structs::*;

    localparam int unsigned KW      = P_WIDTH;
    localparam int          MAX_CYC = 1000;

    typedef struct packed {
        int x;
        int y;
        bit inf;
    } mpt_t;

    logic         clk = 1'b0;
    logic         Reset;
    logic         sa_rst;
    logic         sa_done;
    curve_point_t sa_r;
    curve_point_t g_pt;
    int           checks = 0;
    int           errors = 0;
    int           dbl_ops = 0;
    int           add_ops = 0;
    logic         dbl_prev = 1'b1;
    logic         add_prev = 1'b1;
    logic         overlap = 1'b0;

    point_scalar_mult_if #(.K_WIDTH(KW)) bus ();
    point_scalar_mult #(.K_WIDTH(KW)) dut (.clk(clk), .Reset(Reset), .bus(bus));
    point_double sa (.clk(clk), .Reset(sa_rst), .P(g_pt), .R(sa_r), .Done(sa_done));

    always #5 clk = ~clk;

    // Count sub-unit runs as reset deassertions; flag any overlap of the two.
    always @(negedge clk) begin
        if (dbl_prev && !dut.dbl_reset_c) dbl_ops++;
        if (add_prev && !dut.add_reset_c) add_ops++;
        if (!dut.dbl_reset_c && !dut.add_reset_c) overlap = 1'b1;
        dbl_prev = dut.dbl_reset_c;
        add_prev = dut.add_reset_c;
    end

    function automatic int md(int a);
        return ((a % int'(P_MOD)) + int'(P_MOD)) % int'(P_MOD);
    endfunction

    function automatic int minv(int a);
        int r = 1;
        for (int e = 0; e < int'(P_MOD) - 2; e++) r = md(r * a);
        return r;
    endfunction

    function automatic mpt_t madd(mpt_t a, mpt_t b);
        mpt_t r;
        int   lam;
        if (a.inf) return b;
        if (b.inf) return a;
        r = '{x: 0, y: 0, inf: 1'b1};
        if (a.x == b.x && md(a.y + b.y) == 0) return r;
        if (a.x == b.x) lam = md((3 * a.x * a.x + int'(CURVE_A)) * minv(md(2 * a.y)));
        else            lam = md((b.y - a.y) * minv(md(b.x - a.x)));
        r.x   = md(lam * lam - a.x - b.x);
        r.y   = md(lam * (a.x - r.x) - a.y);
        r.inf = 1'b0;
        return r;
    endfunction

    function automatic mpt_t mmul(int k, mpt_t p);
        mpt_t r = '{x: 0, y: 0, inf: 1'b1};
        for (int n = 0; n < k; n++) r = madd(r, p);
        return r;
    endfunction

    function automatic curve_point_t to_pt(mpt_t m);
        curve_point_t c;
        c.x = m.inf ? '0 : P_WIDTH'(m.x);
        c.y = m.inf ? '0 : P_WIDTH'(m.y);
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (bus.Done !== 1'b1 && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_timeout"}, 32'(cyc < MAX_CYC), 32'd1);
    endtask

    task automatic issue(input int kval, input curve_point_t pval);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k     = KW'(kval);
        bus.P     = pval;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input int kval, input curve_point_t pval,
                          output int cyc, output int nd, output int na);
        int d0, a0;
        d0 = dbl_ops;
        a0 = add_ops;
        issue(kval, pval);
        wait_done(tag, cyc);
        @(negedge clk);
        nd = dbl_ops - d0;
        na = add_ops - a0;
    endtask

    task automatic check_result(input string tag, input mpt_t exp);
        check({tag, "_R"}, 32'(bus.R), 32'(to_pt(exp)));
        check({tag, "_Rinf"}, 32'(bus.R_inf), 32'(exp.inf));
    endtask

    initial begin
        mpt_t gm, pm, em;
        int   cyc, nd, na, kv, jv, n;
        string tag;

        gm        = '{x: int'(G_X), y: int'(G_Y), inf: 1'b0};
        g_pt      = to_pt(gm);
        Reset     = 1'b1;
        sa_rst    = 1'b1;
        bus.start = 1'b0;
        bus.k     = '0;
        bus.P     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_R", 32'(bus.R), 32'd0);
        check("rst_Rinf", 32'(bus.R_inf), 32'd0);
        Reset  = 1'b0;
        sa_rst = 1'b0;

        // Standalone doubling of G as a second reference for k=2.
        n = 0;
        while (sa_done !== 1'b1 && n < MAX_CYC) begin
            @(negedge clk);
            n++;
        end
        check("sa_timeout", 32'(n < MAX_CYC), 32'd1);

        run_op("k0", 0, g_pt, cyc, nd, na);
        check("k0_cycles", 32'(cyc), 32'(KW + 1));
        check_result("k0", '{x: 0, y: 0, inf: 1'b1});
        check("k0_dbl", 32'(nd), 32'd0);
        check("k0_add", 32'(na), 32'd0);

        run_op("k1", 1, g_pt, cyc, nd, na);
        check_result("k1", gm);
        check("k1_dbl", 32'(nd), 32'd0);
        check("k1_add", 32'(na), 32'd0);

        run_op("k2", 2, g_pt, cyc, nd, na);
        check_result("k2", mmul(2, gm));
        check("k2_vs_dbl", 32'(bus.R), 32'(sa_r));
        check("k2_dbl", 32'(nd), 32'd1);
        check("k2_add", 32'(na), 32'd0);

        run_op("k5", 5, g_pt, cyc, nd, na);
        check_result("k5", mmul(5, gm));
        check("k5_dbl", 32'(nd), 32'd2);
        check("k5_add", 32'(na), 32'd1);

        run_op("k13", 13, g_pt, cyc, nd, na);
        check_result("k13", mmul(13, gm));
        check("k13_dbl", 32'(nd), 32'd3);
        check("k13_add", 32'(na), 32'd2);

        // Abort a k=13 run while the doubler is active.
        issue(13, g_pt);
        n = 0;
        while (dut.dbl_reset_c && n < MAX_CYC) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_dbl", 32'(n < MAX_CYC), 32'd1);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.Done), 32'd0);
        check("abort_R", 32'(bus.R), 32'd0);
        check("abort_Rinf", 32'(bus.R_inf), 32'd0);
        @(negedge clk);
        Reset = 1'b0;

        // k=2 run with start pulses (other k and P) while busy.
        issue(2, g_pt);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.k     = KW'(31);
            bus.P     = to_pt(mmul(3, gm));
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done("post_abort_k2", cyc);
        check_result("post_abort_k2", mmul(2, gm));
        @(negedge clk);
        check("idle_after_done", 32'(bus.busy), 32'd0);

        run_op("kNm1", int'(N_ORDER) - 1, g_pt, cyc, nd, na);
        check_result("kNm1", '{x: int'(G_X), y: md(-int'(G_Y)), inf: 1'b0});
        run_op("kN", int'(N_ORDER), g_pt, cyc, nd, na);
        check_result("kN", '{x: 0, y: 0, inf: 1'b1});

        for (int t = 0; t < 24; t++) begin
            kv  = int'($urandom_range(0, (1 << KW) - 1));
            jv  = int'($urandom_range(1, N_ORDER - 1));
            pm  = mmul(jv, gm);
            em  = mmul(kv, pm);
            tag = $sformatf("rand%0d_k%0d_j%0d", t, kv, jv);
            run_op(tag, kv, to_pt(pm), cyc, nd, na);
            check_result(tag, em);
        end

        check("unit_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
